// File: rtl/uart_bus_responder_if.sv
// CPU-side 8-bit memory bus between the core and uart_bus_responder.
interface uart_bus_responder_if;
  logic       request;
  logic       write_enable;
  logic [7:0] address;
  logic [7:0] write_data;
  logic       ready;
  logic [7:0] read_data;
  logic       busy;

  // CPU core: drives the access, observes completion.
  modport master (
    output request, write_enable, address, write_data,
    input  ready, read_data, busy
  );

  // Responder: observes the access, drives completion.
  modport slave (
    input  request, write_enable, address, write_data,
    output ready, read_data, busy
  );
endinterface

// File: rtl/uart_bus_responder.sv
// Bus responder that tunnels single CPU memory accesses over a UART 8N1
// link to an off-chip host. Writes send 'W', address, data; reads send
// 'R', address and then wait (without timeout) for the host's reply byte.
module uart_bus_responder #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_bus_responder_if.slave  bus,
  output logic                 uart_tx_o,
  input  logic                 uart_rx_i
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  // Transaction FSM encoding
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_SEND_COMMAND = 3'd1;
  localparam logic [2:0] ST_SEND_ADDRESS = 3'd2;
  localparam logic [2:0] ST_SEND_DATA    = 3'd3;
  localparam logic [2:0] ST_WAIT_READ    = 3'd4;
  localparam logic [2:0] ST_DONE         = 3'd5;

  // Receiver encoding
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Transaction / transmitter state
  logic [2:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_bit_end;
  logic             tx_byte_end;
  logic             sending;

  // Receiver state
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;

  assign tx_bit_end  = (tx_cnt_q == CNT_LAST);
  assign tx_byte_end = tx_bit_end && (tx_bit_q == 4'd9);
  assign sending     = (state_q == ST_SEND_COMMAND) ||
                       (state_q == ST_SEND_ADDRESS) ||
                       (state_q == ST_SEND_DATA);

  // Transaction sequencing and bit-serial transmit of the current byte
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;

    // Advance the serializer; the next line level is set one bit ahead.
    if (sending) begin
      if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd8) begin
          tx_d = 1'b1;
        end else if (tx_bit_q < 4'd8) begin
          tx_d = tx_byte_q[tx_bit_q[2:0]];
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
    end

    // Byte loads below start a new start bit immediately, so consecutive
    // bytes leave the line with no idle gap between stop and start.
    case (state_q)
      ST_IDLE: begin
        if (bus.request) begin
          we_d      = bus.write_enable;
          addr_d    = bus.address;
          wdata_d   = bus.write_data;
          tx_byte_d = bus.write_enable ? CMD_WRITE : CMD_READ;
          tx_d      = 1'b0;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          state_d   = ST_SEND_COMMAND;
        end
      end
      ST_SEND_COMMAND: begin
        if (tx_byte_end) begin
          tx_byte_d = addr_q;
          tx_d      = 1'b0;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          state_d   = ST_SEND_ADDRESS;
        end
      end
      ST_SEND_ADDRESS: begin
        if (tx_byte_end) begin
          if (we_q) begin
            tx_byte_d = wdata_q;
            tx_d      = 1'b0;
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
            state_d   = ST_SEND_DATA;
          end else begin
            state_d = ST_WAIT_READ;
          end
        end
      end
      ST_SEND_DATA: begin
        if (tx_byte_end) begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_READ: begin
        if (rx_valid_q) begin
          rdata_d = rx_shift_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction / transmitter registers; the line idles high from reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tx_q      <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Two-flop synchronizer for the asynchronous host line, plus one delay
  // stage of the synchronized level for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Free-running receiver: start re-check at mid-bit, centre sampling,
  // delivery only for a good stop bit sampled while a read is waiting
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_valid_d = rx_s2_q && (state_q == ST_WAIT_READ);
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Receiver registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.ready     = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.read_data = rdata_q;
  assign uart_tx_o     = tx_q;

endmodule

// File: doc/uart_bus_responder.md
# uart_bus_responder

Responder end of the CPU's 8-bit memory bus (address / write_enable / write_data / read_data), placed between the CPU core and the Tiny Tapeout pins. It accepts one bus access at a time and serializes it over a UART 8N1 link to an off-chip host that models memory. For reads it waits for the host's reply byte before completing. This reduces the memory interface to two pins.

## Interface

Parameters:
- CLOCKS_PER_BIT, default 16: UART bit period in clk cycles; must be an even integer ≥ 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request  input  1  CPU access request; level, held with other inputs stable until `ready`.
- write_enable  input  1  1 = write, 0 = read; sampled at acceptance.
- address  input  8  bus address; sampled at acceptance.
- write_data  input  8  write data; sampled at acceptance.
- ready  output  1  one-cycle completion pulse.
- read_data  output  8  last read result; updated only on read completion.
- busy  output  1  high whenever the state is not IDLE.
- uart_tx  output  1  serial out to host; idles high.
- uart_rx  input  1  serial in from host; asynchronous, idles high.

## Operation

- Reset values: uart_tx = 1, ready = 0, busy = 0, read_data = 0x00, FSM = IDLE, receiver idle.
- Frame format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1). Each bit is held CLOCKS_PER_BIT cycles.
- Write transaction sends bytes 0x57, address, write_data back-to-back, with no idle gap.
- Read transaction sends bytes 0x52, address, then waits for one byte on uart_rx.
- FSM states: IDLE, SEND_COMMAND, SEND_ADDRESS, SEND_DATA, WAIT_READ, DONE.
  - IDLE & request: latch write_enable, address and write_data, then go to SEND_COMMAND.
  - SEND_COMMAND → SEND_ADDRESS at the end of the stop bit.
  - SEND_ADDRESS → SEND_DATA if write, else WAIT_READ, at the end of the stop bit.
  - SEND_DATA → DONE at the end of the stop bit.
  - WAIT_READ → DONE on a valid received byte. That byte is loaded into read_data.
  - DONE: ready = 1 for that cycle, then unconditionally go to IDLE.
- Receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at mid-bit (CLOCKS_PER_BIT/2 cycles). If it is high, the frame is a glitch and is ignored.
  - Data bits and the stop bit are sampled at their centres.
  - A stop bit sampled as 0 is a framing error: the byte is discarded and WAIT_READ continues.
  - The receiver runs continuously. A byte is delivered only if its stop-bit sample occurs while in WAIT_READ; otherwise it is discarded.
- No timeout: a read stalls until the host replies.
- Request inputs changing mid-transaction have no effect, because they were latched at acceptance.
- If request is still high in the IDLE cycle after DONE, a new transaction is accepted. The CPU must drop request in the cycle after sampling ready unless it wants another access.
- Reset mid-operation (rst_n low at any time):
  - Immediately forces all outputs to their reset values; uart_tx goes high asynchronously.
  - Any partial frame is abandoned.
  - No ready is produced for the aborted access.

## Timing

- Acceptance happens on the edge where the FSM is in IDLE and request = 1 (cycle T).
- The start bit of the command byte drives uart_tx from cycle T+1.
- Write: 30 × CLOCKS_PER_BIT cycles on the line; ready is high in cycle T+1+30·CLOCKS_PER_BIT.
- Read:
  - Ready is high 2 cycles after the stop-bit centre sample of the reply. The sample is taken on the synchronized input, so add 2 cycles of synchronizer latency.
  - read_data changes in the same cycle that ready rises, and is held until the next read completes.
- busy rises in cycle T+1 and falls in the cycle after ready.
- Minimum gap between transactions is one IDLE cycle. uart_tx is high during that cycle.

## Test plan

All scenarios use CLOCKS_PER_BIT = 4.

- Reset: assert rst_n low, then release -> uart_tx = 1, ready = 0, busy = 0, read_data = 0x00.
- Write to address 0x3C with data 0xA5 -> decoded bytes 0x57, 0x3C, 0xA5. The line is busy for exactly 120 cycles. ready pulses once, at T+121. read_data stays 0x00.
- Read from address 0x10; host replies 0x5A after 20 idle bit-times:
  - uart_tx carries 0x52, 0x10.
  - busy stays high while waiting.
  - ready pulses once and read_data = 0x5A, held until the next read completes.
- Read where the host first sends a byte with stop bit = 0, then a 1-cycle low glitch, then 0xC3 -> only 0xC3 is delivered, with a single ready pulse.
- Host sends byte 0x77 while the FSM is in IDLE, then a write occurs -> 0x77 is discarded, read_data is unchanged, and the write completes normally.
- Pull rst_n low during the address byte of a write -> uart_tx goes high in the same cycle and no ready pulse occurs. After release, a read of 0x01 completes correctly. Holding request high through ready starts a second access one cycle after IDLE.
